// File: rtl/mcif_rd_wrr_os_arb_pkg.sv
// Shared constants, client indices, FSM state and output payload type for the
// MCIF read-ingress weighted round-robin arbiter.
package mcif_rd_arb_pkg;

  localparam int unsigned NUM_REQ = 8;
  localparam int unsigned PD_W    = 47;
  localparam int unsigned WT_W    = 8;
  localparam int unsigned OS_W    = 8;
  localparam int unsigned ID_W    = $clog2(NUM_REQ);
  localparam int unsigned CNT_W   = OS_W + 1;

  // Client slot assignment on the read ingress
  localparam int unsigned CDMA_DAT = 0;
  localparam int unsigned CDMA_WT  = 1;
  localparam int unsigned SDP      = 2;
  localparam int unsigned SDP_B    = 3;
  localparam int unsigned SDP_N    = 4;
  localparam int unsigned PDP      = 5;
  localparam int unsigned CDP      = 6;
  localparam int unsigned SPARE    = 7;

  typedef enum logic [0:0] {
    ST_ARB  = 1'b0,
    ST_HOLD = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [PD_W-1:0] pd;
  } arb_out_t;

endpackage

// File: rtl/mcif_rd_wrr_os_arb_if.sv
// Client request bus plus the single arbitrated request stream.
//   slave  : arbiter view (takes requests, drives the output stream)
//   master : client/downstream view
interface mcif_rd_wrr_os_arb_if;
  import mcif_rd_arb_pkg::*;

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ*PD_W-1:0] req_pd;
  logic                    arb_out_valid;
  logic                    arb_out_ready;
  logic [PD_W-1:0]         arb_out_pd;
  logic [ID_W-1:0]         arb_out_id;

  modport slave (
    input  req_valid, req_pd, arb_out_ready,
    output req_ready, arb_out_valid, arb_out_pd, arb_out_id
  );

  modport master (
    output req_valid, req_pd, arb_out_ready,
    input  req_ready, arb_out_valid, arb_out_pd, arb_out_id
  );

endinterface

// File: rtl/mcif_rd_rr_pick.sv
// Rotating-priority picker: first set bit of elig at or above rr_ptr, wrapping.
// Ports: elig (eligible mask), rr_ptr (start index) -> gnt (one-hot), idx, any.
module mcif_rd_rr_pick
  import mcif_rd_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] elig,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  logic [ID_W-1:0] pos;

  always_comb begin : scan
    gnt = '0;
    idx = '0;
    any = 1'b0;
    pos = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      pos = ID_W'((32'(rr_ptr) + off) % NUM_REQ);
      if (!any && elig[pos]) begin
        any      = 1'b1;
        gnt[pos] = 1'b1;
        idx      = pos;
      end
    end
  end

endmodule

// File: rtl/mcif_rd_wrr_os_arb.sv
// Weighted round-robin read arbiter with an outstanding-request throttle.
// Ports:
//   nvdla_core_clk / nvdla_core_rst : clock, synchronous active-high reset
//   bus (slave)      : per-client valid/ready/pd in, registered request out
//   reg2dp_rd_weight : per-client weights, 0 masks the client
//   reg2dp_rd_os_cnt : in-flight limit minus one
//   eg2ig_axi_vld    : pulse per completed read
//   os_cnt_cur       : current in-flight count
module mcif_rd_wrr_os_arb
  import mcif_rd_arb_pkg::*;
(
  input  logic                    nvdla_core_clk,
  input  logic                    nvdla_core_rst,
  mcif_rd_wrr_os_arb_if.slave     bus,
  input  logic [NUM_REQ*WT_W-1:0] reg2dp_rd_weight,
  input  logic [OS_W-1:0]         reg2dp_rd_os_cnt,
  input  logic                    eg2ig_axi_vld,
  output logic [OS_W:0]           os_cnt_cur
);

  arb_state_e       state_q, state_d;
  logic [WT_W-1:0]  credit_q   [NUM_REQ];
  logic [WT_W-1:0]  credit_eff [NUM_REQ];
  logic [WT_W-1:0]  weight     [NUM_REQ];
  logic [NUM_REQ-1:0] want, elig_raw, elig;
  logic             refresh;
  logic [ID_W-1:0]  rr_ptr_q;
  logic [NUM_REQ-1:0] pick_oh;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_any;
  logic [PD_W-1:0]  pick_pd;
  logic [CNT_W-1:0] os_cnt_q;
  logic             os_ok, out_free, arb_en, grant;
  logic             out_valid_q;
  arb_out_t         out_q;

  // Eligibility; credits are reloaded from weights when requesters exist but all are out of credit
  always_comb begin : eligibility
    refresh = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      weight[i]   = reg2dp_rd_weight[i*WT_W +: WT_W];
      want[i]     = bus.req_valid[i] && (weight[i] != '0);
      elig_raw[i] = want[i] && (credit_q[i] != '0);
    end
    refresh = (elig_raw == '0) && (want != '0);
    for (int i = 0; i < NUM_REQ; i++) begin
      credit_eff[i] = refresh ? weight[i] : credit_q[i];
      elig[i]       = want[i] && (credit_eff[i] != '0);
    end
  end

  mcif_rd_rr_pick u_pick (
    .elig   (elig),
    .rr_ptr (rr_ptr_q),
    .gnt    (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Payload of the picked client
  always_comb begin : pd_mux
    pick_pd = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_oh[i]) pick_pd = bus.req_pd[i*PD_W +: PD_W];
    end
  end

  // Granted-but-unaccepted requests already sit in os_cnt_q, so they throttle too
  assign os_ok    = os_cnt_q <= CNT_W'(reg2dp_rd_os_cnt);
  assign out_free = !out_valid_q || bus.arb_out_ready;

  // Next-state and grant qualification
  always_comb begin : fsm_comb
    state_d = state_q;
    arb_en  = 1'b0;
    grant   = 1'b0;
    unique case (state_q)
      ST_ARB: begin
        arb_en = out_free && os_ok && !nvdla_core_rst;
        grant  = arb_en && pick_any;
        if (out_valid_q && !bus.arb_out_ready) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (bus.arb_out_ready) state_d = ST_ARB;
      end
      default: state_d = ST_ARB;
    endcase
  end

  always_ff @(posedge nvdla_core_clk) begin : state_reg
    if (nvdla_core_rst) state_q <= ST_ARB;
    else                state_q <= state_d;
  end

  // Credits and round-robin pointer only move on an arbitration opportunity
  always_ff @(posedge nvdla_core_clk) begin : credit_reg
    if (nvdla_core_rst) begin
      for (int i = 0; i < NUM_REQ; i++) credit_q[i] <= '0;
      rr_ptr_q <= '0;
    end else if (arb_en) begin
      for (int i = 0; i < NUM_REQ; i++) credit_q[i] <= credit_eff[i];
      if (grant) begin
        credit_q[pick_idx] <= credit_eff[pick_idx] - WT_W'(1);
        rr_ptr_q <= (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + ID_W'(1);
      end
    end
  end

  // Output request register
  always_ff @(posedge nvdla_core_clk) begin : out_reg
    if (nvdla_core_rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (grant) begin
      out_valid_q <= 1'b1;
      out_q.pd    <= pick_pd;
      out_q.id    <= pick_idx;
    end else if (bus.arb_out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // In-flight counter, saturating both ways; coincident grant and completion cancel
  always_ff @(posedge nvdla_core_clk) begin : os_reg
    if (nvdla_core_rst) begin
      os_cnt_q <= '0;
    end else begin
      unique case ({grant, eg2ig_axi_vld})
        2'b10:   if (os_cnt_q != '1) os_cnt_q <= os_cnt_q + CNT_W'(1);
        2'b01:   if (os_cnt_q != '0) os_cnt_q <= os_cnt_q - CNT_W'(1);
        default: os_cnt_q <= os_cnt_q;
      endcase
    end
  end

  assign bus.req_ready     = grant ? pick_oh : '0;
  assign bus.arb_out_valid = out_valid_q;
  assign bus.arb_out_pd    = out_q.pd;
  assign bus.arb_out_id    = out_q.id;
  assign os_cnt_cur        = os_cnt_q;

endmodule

// File: tb/tb_mcif_rd_wrr_os_arb.sv
// Directed bench for the MCIF read WRR arbiter with outstanding throttle.
module tb_mcif_rd_wrr_os_arb;
  import mcif_rd_arb_pkg::*;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [NUM_REQ*WT_W-1:0] weight;
  logic [OS_W-1:0]         os_lim;
  logic                    eg;
  logic [OS_W:0]           os_cnt_cur;

  int total = 0;
  int bad   = 0;

  mcif_rd_wrr_os_arb_if ifc ();

  mcif_rd_wrr_os_arb dut (
    .nvdla_core_clk   (clk),
    .nvdla_core_rst   (rst),
    .bus              (ifc),
    .reg2dp_rd_weight (weight),
    .reg2dp_rd_os_cnt (os_lim),
    .eg2ig_axi_vld    (eg),
    .os_cnt_cur       (os_cnt_cur)
  );

  always #5 clk = ~clk;

  function automatic logic [PD_W-1:0] pd_of(input int i);
    logic [63:0] t;
    t = 64'h0000_5A00_0000_0001 | (64'(i) << 40) | (64'(i) * 64'h0000_0000_0101_0101);
    return PD_W'(t);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ifc.req_valid = '0;
    eg = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    ifc.arb_out_ready = 1'b1;
    weight = {NUM_REQ{8'd1}};
    os_lim = 8'd255;
    do_reset();
    total++; if (ifc.arb_out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h exp=0", ifc.arb_out_valid); end
    total++; if (ifc.arb_out_pd !== '0) begin bad++; $display("FAIL reset_pd got=%0h exp=0", ifc.arb_out_pd); end
    total++; if (ifc.arb_out_id !== '0) begin bad++; $display("FAIL reset_id got=%0h exp=0", ifc.arb_out_id); end
    total++; if (os_cnt_cur !== '0) begin bad++; $display("FAIL reset_os got=%0d exp=0", os_cnt_cur); end
    total++; if (ifc.req_ready !== '0) begin bad++; $display("FAIL reset_ready got=%0h exp=0", ifc.req_ready); end
  endtask

  // Clients 0,3,5 at weight 1 with downstream always ready: back-to-back rotation
  task automatic test_rr();
    int exp_id [6] = '{0, 3, 5, 0, 3, 5};
    do_reset();
    weight = {NUM_REQ{8'd1}};
    os_lim = 8'd255;
    ifc.arb_out_ready = 1'b1;
    ifc.req_valid = 8'b0010_1001;
    #1;
    total++; if (ifc.req_ready !== 8'h01) begin bad++; $display("FAIL rr_first_ready got=%0h exp=01", ifc.req_ready); end
    total++; if (ifc.arb_out_valid !== 1'b0) begin bad++; $display("FAIL rr_latency got=%0h exp=0", ifc.arb_out_valid); end
    for (int k = 0; k < 6; k++) begin
      tick();
      total++; if (ifc.arb_out_valid !== 1'b1) begin bad++; $display("FAIL rr_valid[%0d] got=%0h exp=1", k, ifc.arb_out_valid); end
      total++; if (ifc.arb_out_id !== ID_W'(exp_id[k])) begin bad++; $display("FAIL rr_id[%0d] got=%0d exp=%0d", k, ifc.arb_out_id, exp_id[k]); end
      total++; if (ifc.arb_out_pd !== pd_of(exp_id[k])) begin bad++; $display("FAIL rr_pd[%0d] got=%0h exp=%0h", k, ifc.arb_out_pd, pd_of(exp_id[k])); end
    end
    ifc.req_valid = '0;
    tick();
    total++; if (ifc.arb_out_valid !== 1'b0) begin bad++; $display("FAIL rr_drop got=%0h exp=0", ifc.arb_out_valid); end
    total++; if (os_cnt_cur !== 9'd6) begin bad++; $display("FAIL rr_os got=%0d exp=6", os_cnt_cur); end
    eg = 1'b1;
    repeat (6) tick();
    eg = 1'b0;
    total++; if (os_cnt_cur !== 9'd0) begin bad++; $display("FAIL rr_drain got=%0d exp=0", os_cnt_cur); end
  endtask

  // w0=3, w1=1, client 2 valid with weight 0
  task automatic test_wrr();
    int exp_id [12] = '{0, 1, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0};
    do_reset();
    weight = {8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd0, 8'd1, 8'd3};
    os_lim = 8'd255;
    ifc.arb_out_ready = 1'b1;
    ifc.req_valid = 8'b0000_0111;
    for (int k = 0; k < 12; k++) begin
      tick();
      total++; if (ifc.arb_out_valid !== 1'b1 || ifc.arb_out_id !== ID_W'(exp_id[k])) begin
        bad++; $display("FAIL wrr_id[%0d] got=%0d/v%0d exp=%0d", k, ifc.arb_out_id, ifc.arb_out_valid, exp_id[k]);
      end
    end
    ifc.req_valid = '0;
  endtask

  // Limit of 2 in flight, then release one slot
  task automatic test_throttle();
    int ngr;
    do_reset();
    weight = {NUM_REQ{8'd1}};
    os_lim = 8'd1;
    ifc.arb_out_ready = 1'b1;
    ifc.req_valid = 8'b0000_0011;
    ngr = 0;
    repeat (5) begin tick(); if (ifc.arb_out_valid) ngr++; end
    total++; if (ngr != 2) begin bad++; $display("FAIL thr_grants got=%0d exp=2", ngr); end
    total++; if (ifc.req_ready !== '0) begin bad++; $display("FAIL thr_blocked got=%0h exp=0", ifc.req_ready); end
    total++; if (os_cnt_cur !== 9'd2) begin bad++; $display("FAIL thr_os got=%0d exp=2", os_cnt_cur); end
    eg = 1'b1;
    tick();
    eg = 1'b0;
    total++; if (os_cnt_cur !== 9'd1) begin bad++; $display("FAIL thr_dec got=%0d exp=1", os_cnt_cur); end
    ngr = 0;
    repeat (4) begin tick(); if (ifc.arb_out_valid) ngr++; end
    total++; if (ngr != 1) begin bad++; $display("FAIL thr_regrant got=%0d exp=1", ngr); end
    total++; if (os_cnt_cur !== 9'd2) begin bad++; $display("FAIL thr_os2 got=%0d exp=2", os_cnt_cur); end
  endtask

  // Continues from test_throttle: count 2, client 1 next in line
  task automatic test_os_sat();
    os_lim = 8'd255;
    eg = 1'b1;
    #1;
    total++; if (ifc.req_ready !== 8'h02) begin bad++; $display("FAIL sat_ready got=%0h exp=02", ifc.req_ready); end
    tick();
    eg = 1'b0;
    ifc.req_valid = '0;
    total++; if (os_cnt_cur !== 9'd2) begin bad++; $display("FAIL sat_same got=%0d exp=2", os_cnt_cur); end
    total++; if (ifc.arb_out_id !== 3'd1) begin bad++; $display("FAIL sat_id got=%0d exp=1", ifc.arb_out_id); end
    eg = 1'b1;
    tick();
    tick();
    total++; if (os_cnt_cur !== 9'd0) begin bad++; $display("FAIL sat_drain got=%0d exp=0", os_cnt_cur); end
    tick();
    eg = 1'b0;
    total++; if (os_cnt_cur !== 9'd0) begin bad++; $display("FAIL sat_floor got=%0d exp=0", os_cnt_cur); end
  endtask

  // Downstream stall for 4 cycles after a grant
  task automatic test_hold();
    do_reset();
    weight = {NUM_REQ{8'd1}};
    os_lim = 8'd255;
    ifc.arb_out_ready = 1'b0;
    ifc.req_valid = 8'b0001_0100;
    #1;
    total++; if (ifc.req_ready !== 8'h04) begin bad++; $display("FAIL hold_first got=%0h exp=04", ifc.req_ready); end
    tick();
    for (int k = 0; k < 4; k++) begin
      total++; if (ifc.arb_out_valid !== 1'b1 || ifc.arb_out_id !== 3'd2) begin
        bad++; $display("FAIL hold_out[%0d] got=v%0d/id%0d exp=v1/id2", k, ifc.arb_out_valid, ifc.arb_out_id);
      end
      total++; if (ifc.arb_out_pd !== pd_of(2)) begin bad++; $display("FAIL hold_pd[%0d] got=%0h exp=%0h", k, ifc.arb_out_pd, pd_of(2)); end
      total++; if (ifc.req_ready !== '0) begin bad++; $display("FAIL hold_ready[%0d] got=%0h exp=0", k, ifc.req_ready); end
      tick();
    end
    ifc.arb_out_ready = 1'b1;
    #1;
    total++; if (ifc.req_ready !== '0) begin bad++; $display("FAIL hold_release_ready got=%0h exp=0", ifc.req_ready); end
    tick();
    total++; if (ifc.arb_out_valid !== 1'b0) begin bad++; $display("FAIL hold_accepted got=%0h exp=0", ifc.arb_out_valid); end
    total++; if (ifc.req_ready !== 8'h10) begin bad++; $display("FAIL hold_next_ready got=%0h exp=10", ifc.req_ready); end
    tick();
    total++; if (ifc.arb_out_valid !== 1'b1 || ifc.arb_out_id !== 3'd4) begin
      bad++; $display("FAIL hold_next_id got=v%0d/id%0d exp=v1/id4", ifc.arb_out_valid, ifc.arb_out_id);
    end
    tick();
    total++; if (ifc.arb_out_id !== 3'd2) begin bad++; $display("FAIL hold_refresh_id got=%0d exp=2", ifc.arb_out_id); end
    total++; if (os_cnt_cur !== 9'd3) begin bad++; $display("FAIL hold_os got=%0d exp=3", os_cnt_cur); end
    ifc.req_valid = '0;
  endtask

  // Reset while stalled with 5 in flight
  task automatic test_reset_hold();
    do_reset();
    weight = {NUM_REQ{8'd1}};
    os_lim = 8'd255;
    ifc.arb_out_ready = 1'b1;
    ifc.req_valid = 8'b0100_1010;
    repeat (5) tick();
    total++; if (ifc.arb_out_id !== 3'd3) begin bad++; $display("FAIL rsth_pre_id got=%0d exp=3", ifc.arb_out_id); end
    ifc.arb_out_ready = 1'b0;
    tick();
    tick();
    total++; if (os_cnt_cur !== 9'd5 || ifc.arb_out_valid !== 1'b1) begin
      bad++; $display("FAIL rsth_pre_os got=%0d/v%0d exp=5/v1", os_cnt_cur, ifc.arb_out_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (ifc.arb_out_valid !== 1'b0) begin bad++; $display("FAIL rsth_valid got=%0h exp=0", ifc.arb_out_valid); end
    total++; if (os_cnt_cur !== 9'd0) begin bad++; $display("FAIL rsth_os got=%0d exp=0", os_cnt_cur); end
    total++; if (ifc.arb_out_id !== '0 || ifc.arb_out_pd !== '0) begin
      bad++; $display("FAIL rsth_out got=id%0d/pd%0h exp=0/0", ifc.arb_out_id, ifc.arb_out_pd);
    end
    ifc.req_valid = '0;
    eg = 1'b1;
    tick();
    eg = 1'b0;
    total++; if (os_cnt_cur !== 9'd0) begin bad++; $display("FAIL rsth_late_eg got=%0d exp=0", os_cnt_cur); end
    ifc.req_valid = 8'b0100_1010;
    ifc.arb_out_ready = 1'b1;
    #1;
    total++; if (ifc.req_ready !== 8'h02) begin bad++; $display("FAIL rsth_ready got=%0h exp=02", ifc.req_ready); end
    tick();
    total++; if (ifc.arb_out_valid !== 1'b1 || ifc.arb_out_id !== 3'd1) begin
      bad++; $display("FAIL rsth_first_id got=v%0d/id%0d exp=v1/id1", ifc.arb_out_valid, ifc.arb_out_id);
    end
    ifc.req_valid = '0;
  endtask

  initial begin
    rst = 1'b1;
    eg = 1'b0;
    weight = '0;
    os_lim = '0;
    ifc.req_valid = '0;
    ifc.arb_out_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) ifc.req_pd[i*PD_W +: PD_W] = pd_of(i);
    test_reset();
    test_rr();
    test_wrr();
    test_throttle();
    test_os_sat();
    test_hold();
    test_reset_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mcif_rd_wrr_os_arb.md
Name: mcif_rd_wrr_os_arb

Overview:
- Weighted round-robin arbiter with outstanding-request throttle for the MCIF read ingress path.
- Selects one of NUM_REQ client read requests per cycle using per-client programmable weights and drives a single registered request stream toward the AXI AR formatter.
- Stalls all grants when the in-flight read count reaches the programmed limit.
- The in-flight count is decremented by the egress-side completion pulse (eg2ig_axi_vld).

Parameters:
NUM_REQ, 8, number of read clients (cdma_dat, cdma_wt, sdp, sdp_b, sdp_n, pdp, cdp, spare)
PD_W, 47, request payload width (address + size)
WT_W, 8, weight field width per client
OS_W, 8, outstanding limit register width
ID_W, 3, client index width, equal to clog2(NUM_REQ)

Ports:
nvdla_core_clk  in  1  core clock
nvdla_core_rst  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  per-client request valid
req_ready  out  NUM_REQ  per-client accept (one-hot or zero)
req_pd  in  NUM_REQ*PD_W  per-client payloads, client i at [i*PD_W +: PD_W]
reg2dp_rd_weight  in  NUM_REQ*WT_W  per-client weights; 0 = client masked
reg2dp_rd_os_cnt  in  OS_W  max in-flight reads minus 1
eg2ig_axi_vld  in  1  one-cycle pulse: one read fully returned
arb_out_valid  out  1  registered request valid
arb_out_ready  in  1  downstream accept
arb_out_pd  out  PD_W  granted payload
arb_out_id  out  ID_W  granted client index
os_cnt_cur  out  OS_W+1  current in-flight count (status)

Behaviour:
- Reset (synchronous, active-high; one clock; no async path): arb_out_valid=0, arb_out_pd=0, arb_out_id=0, req_ready=0, os_cnt_cur=0, all credit counters=0, rr pointer=0, FSM=ARB.
- Reset asserted mid-operation drops any held output request and clears the in-flight count; late eg2ig_axi_vld pulses after reset saturate at 0 (no underflow).
- Eligibility for client i: req_valid[i] && weight[i]!=0 && credit[i]!=0.
- Refresh: if no client is eligible but at least one has req_valid && weight!=0, reload every credit[i]=weight[i] in that cycle and arbitrate on the reloaded values. A grant is still possible that same cycle.
- Pick: first eligible client scanning from rr_ptr upward, wrapping NUM_REQ-1 -> 0.
- On grant: credit[i]-=1 and rr_ptr=i+1 mod NUM_REQ. rr_ptr holds when no grant.
- Throttle: grant allowed only when os_cnt_cur <= reg2dp_rd_os_cnt, i.e. limit is reg2dp_rd_os_cnt+1 in flight. Counts granted but not yet accepted downstream are included.
- os_cnt_cur increments on grant and decrements on eg2ig_axi_vld. Simultaneous grant and eg2ig_axi_vld leaves it unchanged. It saturates at 2^(OS_W+1)-1 and at 0.
- Lowering reg2dp_rd_os_cnt below the current count blocks grants until the count drains. No flush.
- FSM states:
  - ARB: may grant. req_ready[i]=1 combinationally for the picked client only when output register empty or being accepted this cycle. Grant loads pd/id into the output register; arb_out_valid=1 next cycle (latency 1).
  - HOLD: entered when arb_out_valid && !arb_out_ready. Output stable, all req_ready=0, no credit/ptr change. Returns to ARB on arb_out_ready.
- Back-to-back: with arb_out_ready high, one grant per cycle, full throughput.
- Weights may change at any time. New values take effect at the next refresh only.

Decomposition:
- Package mcif_rd_arb_pkg: NUM_REQ, PD_W, WT_W, OS_W, ID_W, client index constants (CDMA_DAT=0, CDMA_WT=1, SDP=2, SDP_B=3, SDP_N=4, PDP=5, CDP=6, SPARE=7), FSM state enum.
- Sub-module mcif_rd_rr_pick: combinational rotating-priority picker. Inputs: eligible mask and rr_ptr. Outputs: one-hot grant, index, any.

Test Plan:
- Weights all 1, clients 0,3,5 valid continuously, os_cnt=255, ready=1 -> grants 0,3,5,0,3,5 on consecutive cycles; arb_out_valid first asserts 1 cycle after first req_valid.
- Weights w0=3,w1=1, both valid -> grant pattern 0,0,0,1 repeating; weight 2 set to 0 with valid -> client 2 never granted.
- reg2dp_rd_os_cnt=1, no eg2ig_axi_vld -> exactly 2 grants then all req_ready=0; one eg2ig_axi_vld pulse -> exactly one more grant, os_cnt_cur=2.
- Grant and eg2ig_axi_vld in the same cycle with os_cnt_cur=2 -> os_cnt_cur stays 2; eg2ig_axi_vld with count 0 -> stays 0.
- arb_out_ready held low 4 cycles after grant -> arb_out_pd/id stable, req_ready=0, credits frozen; on release, next grant proceeds from rr_ptr.
- Reset pulsed while in HOLD with os_cnt_cur=5 -> next cycle arb_out_valid=0, os_cnt_cur=0, rr_ptr=0, first post-reset grant goes to lowest-index eligible client.
